// File: rtl/ex_pkg.sv
// Shared EX-stage definitions: data width, mul/div opcode encodings, the
// multiply/divide FSM state type and the instruction-word opcode field.
package ex_pkg;

    localparam int XLEN = 32;

    localparam logic [1:0] MULDIV_OP_MUL = 2'b00;
    localparam logic [1:0] MULDIV_OP_DIV = 2'b01;
    localparam logic [1:0] MULDIV_OP_MOD = 2'b10;
    localparam logic [1:0] MULDIV_OP_RSV = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } muldiv_state_e;

    localparam logic [31:0] NOP_INSTR  = 32'h6800_0000;
    localparam int          OPCODE_MSB = 31;
    localparam int          OPCODE_LSB = 27;

    function automatic logic [OPCODE_MSB-OPCODE_LSB:0] opcode_of(input logic [31:0] instr);
        return instr[OPCODE_MSB:OPCODE_LSB];
    endfunction

endpackage

// File: rtl/ex_muldiv_core.sv
// One iteration of the shared datapath: shift-add for multiply, restoring
// subtract for divide. acc holds product/remainder, x multiplier/quotient.
module ex_muldiv_core #(
    parameter int XLEN = ex_pkg::XLEN
) (
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] acc_i,
    input  logic [XLEN-1:0] x_i,
    input  logic [XLEN-1:0] y_i,
    output logic [XLEN-1:0] acc_o,
    output logic [XLEN-1:0] x_o,
    output logic [XLEN-1:0] y_o
);
    import ex_pkg::*;

    logic [XLEN:0] rem_sh;
    logic [XLEN:0] diff;

    // Divisor is a magnitude <= 2^(XLEN-1), so one extra bit keeps the sign exact.
    assign rem_sh = {acc_i, x_i[XLEN-1]};
    assign diff   = rem_sh - {1'b0, y_i};

    always_comb begin
        acc_o = acc_i;
        x_o   = x_i;
        y_o   = y_i;
        if (op_i == MULDIV_OP_MUL) begin
            acc_o = acc_i + (x_i[0] ? y_i : '0);
            x_o   = x_i >> 1;
            y_o   = y_i << 1;
        end else if (!diff[XLEN]) begin
            acc_o = diff[XLEN-1:0];
            x_o   = {x_i[XLEN-2:0], 1'b1};
        end else begin
            acc_o = rem_sh[XLEN-1:0];
            x_o   = {x_i[XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative multiply/divide/modulo unit in the EX stage. Stalls the OF->EX
// latch while busy; all state advances on the falling edge like the latches.
module ex_muldiv_unit #(
    parameter int XLEN = ex_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    input  logic            flush,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic            div_by_zero
);
    import ex_pkg::*;

    localparam int CNT_W = $clog2(XLEN) + 1;

    muldiv_state_e    state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       op_q;
    logic [XLEN-1:0]  acc_q, x_q, y_q, result_q;
    logic             neg_quo_q, neg_rem_q, dbz_q;

    logic [XLEN-1:0]  acc_d, x_d, y_d;
    logic [XLEN-1:0]  a_mag, b_mag, special_res;
    logic             a_neg, b_neg, accept, special;

    assign a_neg  = src_a[XLEN-1];
    assign b_neg  = src_b[XLEN-1];
    assign a_mag  = a_neg ? -src_a : src_a;
    assign b_mag  = b_neg ? -src_b : src_b;
    assign accept = start & ~flush & ((state_q == IDLE) | (state_q == DONE));
    // Zero divisor and the reserved opcode finish without iterating.
    assign special = (op == MULDIV_OP_RSV) | ((op != MULDIV_OP_MUL) & (src_b == '0));

    always_comb begin
        special_res = '0;
        case (op)
            MULDIV_OP_DIV: special_res = '1;
            MULDIV_OP_MOD: special_res = src_a;
            default:       special_res = '0;
        endcase
    end

    assign stall       = (state_q == RUN) | (state_q == FIX) | accept;
    assign done        = (state_q == DONE);
    assign result      = result_q;
    assign div_by_zero = dbz_q;

    ex_muldiv_core #(.XLEN(XLEN)) u_core (
        .op_i  (op_q),
        .acc_i (acc_q),
        .x_i   (x_q),
        .y_i   (y_q),
        .acc_o (acc_d),
        .x_o   (x_d),
        .y_o   (y_d)
    );

    always_ff @(negedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            op_q      <= MULDIV_OP_MUL;
            acc_q     <= '0;
            x_q       <= '0;
            y_q       <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
            dbz_q     <= 1'b0;
        end else if (flush) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    state_q <= IDLE;
                    if (accept) begin
                        op_q <= op;
                        if (special) begin
                            state_q  <= DONE;
                            result_q <= special_res;
                            dbz_q    <= (op != MULDIV_OP_RSV);
                        end else begin
                            state_q   <= RUN;
                            cnt_q     <= CNT_W'(XLEN);
                            acc_q     <= '0;
                            x_q       <= (op == MULDIV_OP_MUL) ? src_b : a_mag;
                            y_q       <= (op == MULDIV_OP_MUL) ? src_a : b_mag;
                            neg_quo_q <= a_neg ^ b_neg;
                            neg_rem_q <= a_neg;
                        end
                    end
                end
                RUN: begin
                    acc_q <= acc_d;
                    x_q   <= x_d;
                    y_q   <= y_d;
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    state_q <= DONE;
                    dbz_q   <= 1'b0;
                    case (op_q)
                        MULDIV_OP_MUL: result_q <= acc_q;
                        MULDIV_OP_DIV: result_q <= neg_quo_q ? -x_q : x_q;
                        default:       result_q <= neg_rem_q ? -acc_q : acc_q;
                    endcase
                end
            endcase
        end
    end

    // Upstream is frozen while busy, so a new start here is a pipeline bug.
    a_no_start_busy: assert property (@(negedge clk) disable iff (rst)
        !(start && !flush && (state_q == RUN || state_q == FIX)));

endmodule
